// File: rtl/pipeline_run_control_if.sv
// -----------------------------------------------------------------------------
// pipeline_run_control_if
//   Bundles the debug-command handshake, the HALT flag from the ID-stage
//   decoder and the enables/status returned by the run sequencer.
//
//   Signals
//     i_cmd_valid   debug command present
//     i_cmd         01 RUN, 10 STEP, 11 ABORT, 00 reserved
//     o_cmd_ready   sequencer can take a command this cycle
//     i_halt        HALT opcode decoded for the instruction in ID
//     o_pipe_enable enable for pipeline registers and register-file writes
//     o_pc_enable   enable for PC update / fetch
//     o_running     sequencer is in RUN, STEP or DRAIN
//     o_halted      sequencer is in HALTED
//     o_done        one-cycle completion pulse
//     o_cycle_count saturating count of enabled cycles
//     o_state       encoded sequencer state
//
//   Modports
//     master : debug/pipeline side (drives command and halt)
//     slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface pipeline_run_control_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_cmd_valid;
  logic [1:0]            i_cmd;
  logic                  o_cmd_ready;
  logic                  i_halt;
  logic                  o_pipe_enable;
  logic                  o_pc_enable;
  logic                  o_running;
  logic                  o_halted;
  logic                  o_done;
  logic [DATA_WIDTH-1:0] o_cycle_count;
  logic [2:0]            o_state;

  modport master (
    output i_cmd_valid, i_cmd, i_halt,
    input  o_cmd_ready, o_pipe_enable, o_pc_enable, o_running, o_halted,
           o_done, o_cycle_count, o_state
  );

  modport slave (
    input  i_cmd_valid, i_cmd, i_halt,
    output o_cmd_ready, o_pipe_enable, o_pc_enable, o_running, o_halted,
           o_done, o_cycle_count, o_state
  );
endinterface

// File: rtl/pipeline_run_control.sv
// -----------------------------------------------------------------------------
// pipeline_run_control
//   Execution sequencer for the MIPS pipeline. Gates the global pipeline
//   enable and the PC enable from debug commands (RUN, STEP, ABORT). When the
//   ID-stage decoder flags HALT, fetch is frozen, the in-flight instructions
//   are drained for DRAIN_CYCLES cycles, and completion is reported.
//
//   Parameters
//     DATA_WIDTH   width of the enabled-cycle counter
//     DRAIN_CYCLES cycles run after HALT is seen in ID (EX, MEM, WB); 1..15
//
//   Ports
//     i_clock  system clock, rising edge
//     i_reset  asynchronous, active-low reset
//     bus      pipeline_run_control_if.slave (command, halt, enables, status)
// -----------------------------------------------------------------------------
module pipeline_run_control #(
  parameter int DATA_WIDTH   = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  pipeline_run_control_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_RUN    = 3'b001,
    ST_STEP   = 3'b010,
    ST_DRAIN  = 3'b011,
    ST_HALTED = 3'b100
  } state_t;

  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_ABORT = 2'b11;

  // The drain counter counts down to zero, so the last DRAIN cycle is the one
  // that sees zero; loading DRAIN_CYCLES-1 yields exactly DRAIN_CYCLES cycles.
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t                state_q, state_d;
  logic [3:0]            drain_q, drain_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] count_q;
  logic                  clear_count;
  logic                  cmd_ready;
  logic                  cmd_accept;
  logic                  pipe_enable;
  logic                  pc_enable;

  // Ready is a pure state decode so the debug side never waits on i_halt.
  assign cmd_ready  = (state_q != ST_STEP) && (state_q != ST_DRAIN);
  assign cmd_accept = bus.i_cmd_valid && cmd_ready;

  // ---------------------------------------------------------------------------
  // State, drain counter and done pulse registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      done_q  <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and Moore enables
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default before the case, otherwise
  // paths that leave it unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    done_d      = 1'b0;
    clear_count = 1'b0;
    pipe_enable = 1'b0;
    pc_enable   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_accept && bus.i_cmd == CMD_RUN) begin
          state_d     = ST_RUN;
          clear_count = 1'b1;
        end else if (cmd_accept && bus.i_cmd == CMD_STEP) begin
          state_d = ST_STEP;
        end
      end

      ST_RUN: begin
        pipe_enable = 1'b1;
        // Stop fetching in the very cycle HALT sits in ID.
        pc_enable   = !bus.i_halt;
        if (cmd_accept && bus.i_cmd == CMD_ABORT) begin
          state_d = ST_IDLE;
        end else if (bus.i_halt) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end

      ST_STEP: begin
        pipe_enable = 1'b1;
        pc_enable   = !bus.i_halt;
        if (bus.i_halt) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      ST_DRAIN: begin
        // The PC is frozen on the HALT instruction, so i_halt stays high here
        // and is deliberately not looked at.
        pipe_enable = 1'b1;
        if (drain_q == 4'd0) begin
          state_d = ST_HALTED;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end

      ST_HALTED: begin
        if (cmd_accept && bus.i_cmd == CMD_ABORT) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Enabled-cycle counter: saturates at all-ones instead of wrapping
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      count_q <= '0;
    end else if (clear_count) begin
      count_q <= '0;
    end else if (pipe_enable && count_q != {DATA_WIDTH{1'b1}}) begin
      count_q <= count_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.o_cmd_ready   = cmd_ready;
  assign bus.o_pipe_enable = pipe_enable;
  assign bus.o_pc_enable   = pc_enable;
  assign bus.o_running     = (state_q == ST_RUN) || (state_q == ST_STEP) ||
                             (state_q == ST_DRAIN);
  assign bus.o_halted      = (state_q == ST_HALTED);
  assign bus.o_done        = done_q;
  assign bus.o_cycle_count = count_q;
  assign bus.o_state       = state_q;

endmodule

// File: tb/tb_pipeline_run_control.sv
// -----------------------------------------------------------------------------
// tb_pipeline_run_control
//   Directed bench for pipeline_run_control. Expected observations are queued
//   as the stimulus is planned and popped/compared one per sampled cycle.
//   A second instance with a 4-bit counter covers counter saturation.
// -----------------------------------------------------------------------------
module tb_pipeline_run_control;

  localparam logic [2:0] S_IDLE   = 3'b000;
  localparam logic [2:0] S_RUN    = 3'b001;
  localparam logic [2:0] S_STEP   = 3'b010;
  localparam logic [2:0] S_DRAIN  = 3'b011;
  localparam logic [2:0] S_HALTED = 3'b100;

  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_RUN   = 2'b01;
  localparam logic [1:0] C_STEP  = 2'b10;
  localparam logic [1:0] C_ABORT = 2'b11;

  logic i_clock = 1'b0;
  logic i_reset;

  always #5 i_clock = ~i_clock;

  pipeline_run_control_if #(.DATA_WIDTH(32)) bus  ();
  pipeline_run_control_if #(.DATA_WIDTH(4))  bus4 ();

  pipeline_run_control #(.DATA_WIDTH(32), .DRAIN_CYCLES(3)) u_dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  pipeline_run_control #(.DATA_WIDTH(4), .DRAIN_CYCLES(3)) u_dut4 (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (bus4)
  );

  // Observation vector: {state, pipe_en, pc_en, running, halted, done, ready, count}
  typedef struct {
    string       tag;
    int          inst;
    logic [40:0] v;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  function automatic logic [40:0] mk(input logic [2:0] st, input logic pc,
                                     input logic done, input logic [31:0] cnt);
    logic active;
    active = (st == S_RUN) || (st == S_STEP) || (st == S_DRAIN);
    return {st, active, pc, active, (st == S_HALTED), done,
            !((st == S_STEP) || (st == S_DRAIN)), cnt};
  endfunction

  function automatic logic [40:0] obs(input int inst);
    if (inst == 0)
      return {bus.o_state, bus.o_pipe_enable, bus.o_pc_enable, bus.o_running,
              bus.o_halted, bus.o_done, bus.o_cmd_ready, bus.o_cycle_count};
    else
      return {bus4.o_state, bus4.o_pipe_enable, bus4.o_pc_enable, bus4.o_running,
              bus4.o_halted, bus4.o_done, bus4.o_cmd_ready, 28'd0, bus4.o_cycle_count};
  endfunction

  task automatic push(input string tag, input int inst, input logic [2:0] st,
                      input logic pc, input logic done, input logic [31:0] cnt);
    exp_t e;
    e.tag  = tag;
    e.inst = inst;
    e.v    = mk(st, pc, done, cnt);
    sb_q.push_back(e);
  endtask

  task automatic sample();
    exp_t        e;
    logic [40:0] got;
    total_cnt++;
    if (sb_q.size() == 0) begin
      $error("FAIL sb_empty: observed no queued expectation, required one");
    end else begin
      e   = sb_q.pop_front();
      got = obs(e.inst);
      assert (got === e.v) pass_cnt++;
      else $error("FAIL %s: observed %h required %h", e.tag, got, e.v);
    end
  endtask

  // Drive inputs just after the falling edge, then sample 1 ns later.
  task automatic tick(input logic valid, input logic [1:0] cmd, input logic halt);
    @(negedge i_clock);
    bus.i_cmd_valid = valid;
    bus.i_cmd       = cmd;
    bus.i_halt      = halt;
    #1;
    sample();
  endtask

  task automatic step(input string tag, input logic valid, input logic [1:0] cmd,
                      input logic halt, input logic [2:0] st, input logic pc,
                      input logic done, input logic [31:0] cnt);
    push(tag, 0, st, pc, done, cnt);
    tick(valid, cmd, halt);
  endtask

  task automatic do_reset();
    bus.i_cmd_valid  = 1'b0;
    bus.i_cmd        = C_NONE;
    bus.i_halt       = 1'b0;
    bus4.i_cmd_valid = 1'b0;
    bus4.i_cmd       = C_NONE;
    bus4.i_halt      = 1'b0;
    i_reset          = 1'b0;
    @(negedge i_clock);
    i_reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset values ----------------
    i_reset          = 1'b0;
    bus.i_cmd_valid  = 1'b0;
    bus.i_cmd        = C_NONE;
    bus.i_halt       = 1'b0;
    bus4.i_cmd_valid = 1'b0;
    bus4.i_cmd       = C_NONE;
    bus4.i_halt      = 1'b0;
    push("reset", 0, S_IDLE, 1'b0, 1'b0, 32'd0);
    push("reset4", 1, S_IDLE, 1'b0, 1'b0, 32'd0);
    #1;
    sample();
    sample();
    @(negedge i_clock);
    i_reset = 1'b1;

    // ---------------- RUN, HALT on 10th enabled cycle ----------------
    push("run_cmd", 0, S_IDLE, 1'b0, 1'b0, 32'd0);
    for (int i = 1; i <= 9; i++) push("run_en", 0, S_RUN, 1'b1, 1'b0, 32'(i - 1));
    push("run_halt_pc_off", 0, S_RUN, 1'b0, 1'b0, 32'd9);
    for (int d = 0; d < 3; d++) push("drain", 0, S_DRAIN, 1'b0, 1'b0, 32'(10 + d));
    push("halted_done", 0, S_HALTED, 1'b0, 1'b1, 32'd13);
    tick(1'b1, C_RUN, 1'b0);
    for (int i = 0; i < 9; i++) tick(1'b0, C_NONE, 1'b0);
    tick(1'b0, C_NONE, 1'b1);
    for (int d = 0; d < 3; d++) tick(1'b0, C_NONE, 1'b1);
    tick(1'b0, C_NONE, 1'b0);

    // ---------------- HALTED: RUN ignored, ABORT to IDLE ----------------
    step("halted_run_cmd",    1'b1, C_RUN,   1'b0, S_HALTED, 1'b0, 1'b0, 32'd13);
    step("halted_ignore_run", 1'b0, C_NONE,  1'b0, S_HALTED, 1'b0, 1'b0, 32'd13);
    step("halted_abort_cmd",  1'b1, C_ABORT, 1'b0, S_HALTED, 1'b0, 1'b0, 32'd13);
    step("abort_to_idle",     1'b0, C_NONE,  1'b0, S_IDLE,   1'b0, 1'b0, 32'd13);

    // ---------------- three STEPs, back-to-back on done ----------------
    do_reset();
    step("st1_cmd",  1'b1, C_STEP, 1'b0, S_IDLE, 1'b0, 1'b0, 32'd0);
    step("st1_en",   1'b0, C_NONE, 1'b0, S_STEP, 1'b1, 1'b0, 32'd0);
    step("st1_done", 1'b1, C_STEP, 1'b0, S_IDLE, 1'b0, 1'b1, 32'd1);
    step("st2_en",   1'b0, C_NONE, 1'b0, S_STEP, 1'b1, 1'b0, 32'd1);
    step("st2_done", 1'b1, C_STEP, 1'b0, S_IDLE, 1'b0, 1'b1, 32'd2);
    step("st3_en",   1'b0, C_NONE, 1'b0, S_STEP, 1'b1, 1'b0, 32'd2);
    step("st3_done", 1'b0, C_NONE, 1'b0, S_IDLE, 1'b0, 1'b1, 32'd3);
    step("st_idle",  1'b1, C_NONE, 1'b0, S_IDLE, 1'b0, 1'b0, 32'd3);
    step("idle_reserved", 1'b0, C_NONE, 1'b0, S_IDLE, 1'b0, 1'b0, 32'd3);

    // ---------------- STEP onto a HALT ----------------
    do_reset();
    step("sh_cmd",    1'b1, C_STEP, 1'b0, S_IDLE,   1'b0, 1'b0, 32'd0);
    step("sh_step",   1'b0, C_NONE, 1'b1, S_STEP,   1'b0, 1'b0, 32'd0);
    step("sh_drain0", 1'b0, C_NONE, 1'b1, S_DRAIN,  1'b0, 1'b0, 32'd1);
    step("sh_drain1", 1'b0, C_NONE, 1'b1, S_DRAIN,  1'b0, 1'b0, 32'd2);
    step("sh_drain2", 1'b0, C_NONE, 1'b1, S_DRAIN,  1'b0, 1'b0, 32'd3);
    step("sh_halted", 1'b0, C_NONE, 1'b0, S_HALTED, 1'b0, 1'b1, 32'd4);

    // ---------------- ABORT together with HALT in RUN ----------------
    step("sh_abort",       1'b1, C_ABORT, 1'b0, S_HALTED, 1'b0, 1'b0, 32'd4);
    step("idle_run_cmd",   1'b1, C_RUN,   1'b0, S_IDLE,   1'b0, 1'b0, 32'd4);
    step("run_cleared",    1'b0, C_NONE,  1'b0, S_RUN,    1'b1, 1'b0, 32'd0);
    step("abort_and_halt", 1'b1, C_ABORT, 1'b1, S_RUN,    1'b0, 1'b0, 32'd1);
    step("abort_idle",     1'b0, C_NONE,  1'b0, S_IDLE,   1'b0, 1'b0, 32'd2);
    step("abort_no_done",  1'b1, C_RUN,   1'b0, S_IDLE,   1'b0, 1'b0, 32'd2);
    step("rerun_cleared",  1'b0, C_NONE,  1'b0, S_RUN,    1'b1, 1'b0, 32'd0);
    step("rerun_halt",     1'b0, C_NONE,  1'b1, S_RUN,    1'b0, 1'b0, 32'd1);
    step("drain_pre_rst",  1'b0, C_NONE,  1'b1, S_DRAIN,  1'b0, 1'b0, 32'd2);

    // ---------------- asynchronous reset mid-DRAIN ----------------
    push("async_reset", 0, S_IDLE, 1'b0, 1'b0, 32'd0);
    i_reset = 1'b0;
    #1;
    sample();
    @(negedge i_clock);
    i_reset = 1'b1;
    bus.i_halt = 1'b0;

    // ---------------- 4-bit counter saturation ----------------
    bus4.i_cmd_valid = 1'b1;
    bus4.i_cmd       = C_RUN;
    @(negedge i_clock);
    bus4.i_cmd_valid = 1'b0;
    bus4.i_cmd       = C_NONE;
    #1;
    push("sat_start", 1, S_RUN, 1'b1, 1'b0, 32'd0);
    sample();
    repeat (14) @(negedge i_clock);
    #1;
    push("sat_14", 1, S_RUN, 1'b1, 1'b0, 32'd14);
    sample();
    @(negedge i_clock);
    #1;
    push("sat_15", 1, S_RUN, 1'b1, 1'b0, 32'd15);
    sample();
    repeat (5) @(negedge i_clock);
    #1;
    push("sat_hold", 1, S_RUN, 1'b1, 1'b0, 32'd15);
    sample();

    // ---------------- scoreboard fully consumed ----------------
    total_cnt++;
    assert (sb_q.size() == 0) pass_cnt++;
    else $error("FAIL sb_leftover: observed %0d entries required 0", sb_q.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pipeline_run_control.md
# pipeline_run_control

Execution sequencer for the MIPS pipeline. It gates the global pipeline enable and PC enable from debug commands: continuous run, single step and abort. It detects the HALT opcode flagged by the main instruction decoder in ID, freezes fetch, drains the in-flight instructions, and reports completion to the debug unit. It sits between the debug/UART command logic and the pipeline-register/PC enable inputs.

## Interface
- DATA_WIDTH, 32: width of cycle counter.
- DRAIN_CYCLES, 3: cycles the pipeline keeps running after HALT is seen in ID (EX, MEM, WB); legal range 1..15.
- i_clock  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_cmd_valid  input  1  command present.
- i_cmd  input  2  01 RUN, 10 STEP, 11 ABORT, 00 reserved (accepted, no effect).
- o_cmd_ready  output  1  command can be accepted.
- i_halt  input  1  halt flag from main decoder for the instruction currently in ID.
- o_pipe_enable  output  1  enable for all pipeline registers and register-file writes.
- o_pc_enable  output  1  enable for PC update / fetch.
- o_running  output  1  state is RUN, STEP or DRAIN.
- o_halted  output  1  state is HALTED.
- o_done  output  1  one-cycle completion pulse, registered.
- o_cycle_count  output  DATA_WIDTH  enabled-cycle counter.
- o_state  output  3  current state: IDLE 000, RUN 001, STEP 010, DRAIN 011, HALTED 100.

## Operation
- Command handshake: a command is accepted on a rising edge with i_cmd_valid & o_cmd_ready. o_cmd_ready is 1 in IDLE, RUN and HALTED, and 0 in STEP and DRAIN.
- IDLE: no enables.
  - RUN → RUN; clears o_cycle_count.
  - STEP → STEP; counter is not cleared.
  - ABORT and 00 are accepted with no effect.
- RUN: o_pipe_enable=1; o_pc_enable = ~i_halt.
  - i_halt=1 → DRAIN; drain counter loads DRAIN_CYCLES-1.
  - Accepted ABORT → IDLE; ABORT takes priority over a simultaneous i_halt.
  - RUN, STEP and 00 are accepted and ignored.
- STEP: exactly one enabled cycle; o_pc_enable = ~i_halt.
  - i_halt=1 → DRAIN.
  - Otherwise → IDLE with o_done pulse.
- DRAIN: o_pipe_enable=1, o_pc_enable=0. i_halt is ignored, because the frozen PC re-presents HALT.
  - Drain counter decrements each cycle.
  - At 0 → HALTED.
- HALTED: all enables are 0; o_halted=1.
  - ABORT → IDLE.
  - RUN, STEP and 00 are accepted and ignored.
- o_cycle_count increments on every cycle with o_pipe_enable=1 and saturates at all-ones; there is no wrap.
- o_done is high exactly for the first cycle after entering HALTED from DRAIN, or entering IDLE from STEP. It is not asserted on ABORT.
- Reset (asynchronous, any state, including mid-DRAIN):
  - state IDLE, drain counter 0, o_cycle_count 0, o_done 0.
  - Hence o_pipe_enable=0, o_pc_enable=0, o_running=0, o_halted=0, o_cmd_ready=1, o_state=000.

## Timing
- Enables and status outputs are Moore outputs decoded from registered state. o_pc_enable additionally gates combinationally with i_halt in RUN/STEP.
- Command accepted at edge k → new state and its enables are valid from cycle k+1.
- HALT seen in RUN cycle t:
  - o_pc_enable=0 in cycle t.
  - DRAIN occupies cycles t+1..t+DRAIN_CYCLES.
  - HALTED and o_done=1 at cycle t+DRAIN_CYCLES+1.
  - The counter counts t and all drain cycles.
- STEP accepted at edge k → enabled cycle k+1 → IDLE with o_done at k+2.
- Zero-latency turnaround: from IDLE/HALTED the next command is accepted the same cycle o_done is high.

## Test plan
- Reset mid-DRAIN: assert i_reset=0 asynchronously → outputs return to reset values immediately with no clock; o_state=000, o_cycle_count=0.
- RUN, i_halt high on the 10th enabled cycle, DRAIN_CYCLES=3:
  - pc_enable drops that cycle.
  - 3 drain cycles follow.
  - o_done pulses once, o_halted=1.
  - o_cycle_count=13.
- Three STEP commands with no halt:
  - each gives exactly one o_pipe_enable cycle followed by o_done.
  - o_cycle_count=3.
  - o_cmd_ready=0 during each STEP cycle.
- STEP with i_halt=1 → DRAIN, then HALTED after DRAIN_CYCLES; o_cycle_count=1+DRAIN_CYCLES.
- ABORT and i_halt in the same RUN cycle → IDLE next cycle, no DRAIN, no o_done. Then RUN → counter cleared to 0, then counts from 1.
- In HALTED: RUN command → ignored, state stays 100. ABORT → IDLE, o_halted=0. Counter preloaded near all-ones with DATA_WIDTH=4 saturates at 15.
